// File: rtl/exmpl_run_logger.sv
// Run logger for the A/E/F datapath: times start-to-F runs, counts E rising edges, queues records in a show-ahead FIFO.
// Optional macro EXMPL_LOG_OVF_EN enables the sticky drop flag on ovf_o; otherwise ovf_o is tied low.
module exmpl_run_logger #(
    parameter int unsigned CYC_W = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [3:0]               A_i4,
    input  logic                     E_i,
    input  logic                     F_i,
    output logic [CYC_W+8:0]         rec_o,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o
);

    localparam int unsigned REC_W = CYC_W + 9;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q;
    logic                e_q;
    logic                f_q;
    logic [CYC_W-1:0]    cyc_q;
    logic [CYC_W-1:0]    cyc_d;
    logic [3:0]          ecnt_q;
    logic [3:0]          ecnt_d;
    logic                erise;
    logic                frise;
    logic                timeout;
    logic                push;
    logic [REC_W-1:0]    rec_new;

    logic [REC_W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                rec_valid_q;
    logic                rec_valid_d;
    logic                full;
    logic                pop;
    logic                wr_en;

    // Run bookkeeping: values the counters take if this edge is a RUN edge.
    always_comb begin
        erise   = E_i & ~e_q;
        frise   = F_i & ~f_q;
        cyc_d   = (cyc_q == CYC_MAX) ? CYC_MAX : cyc_q + CYC_W'(1);
        ecnt_d  = ecnt_q;
        if (erise && (ecnt_q != 4'hF)) begin
            ecnt_d = ecnt_q + 4'd1;
        end
        timeout = (cyc_d == CYC_MAX);
        push    = (state_q == S_RUN) && (frise || timeout);
        // Push is only ever F-driven or timeout-driven, so to = ~frise; F wins a tie.
        rec_new = {~frise, A_i4, ecnt_d, cyc_d};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            e_q     <= 1'b0;
            f_q     <= 1'b0;
            cyc_q   <= '0;
            ecnt_q  <= '0;
        end else begin
            e_q <= E_i;
            f_q <= F_i;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        cyc_q   <= '0;
                        ecnt_q  <= '0;
                    end
                end
                S_RUN: begin
                    cyc_q  <= cyc_d;
                    ecnt_q <= ecnt_d;
                    if (frise || timeout) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO control: a push into a full FIFO lands only when the head is popped on the same edge.
    always_comb begin
        pop         = rec_valid_q & rec_ready_i;
        full        = (count_q == CW'(DEPTH));
        wr_en       = push & (~full | pop);
        count_d     = count_q + CW'(wr_en) - CW'(pop);
        rec_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rec_valid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q     <= count_d;
            rec_valid_q <= rec_valid_d;
        end
    end

    // Storage carries no reset; contents are only observed while valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            mem_q[wr_ptr_q] <= rec_new;
        end
    end

    assign rec_o       = mem_q[rd_ptr_q];
    assign rec_valid_o = rec_valid_q;
    assign count_o     = count_q;

`ifdef EXMPL_LOG_OVF_EN
    logic ovf_q;
    logic drop;

    assign drop = push & full & ~pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_exmpl_run_logger.sv
// Directed bench for exmpl_run_logger with a queue-based run model checked every cycle.
module tb_exmpl_run_logger;

    localparam int unsigned CYC_W = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned REC_W = CYC_W + 9;
    localparam int unsigned MAXC  = (1 << CYC_W) - 1;

    logic              clk_i;
    logic              rst_i;
    logic              start_i;
    logic [3:0]        A_i4;
    logic              E_i;
    logic              F_i;
    logic [REC_W-1:0]  rec_o;
    logic              rec_valid_o;
    logic              rec_ready_i;
    logic [2:0]        count_o;
    logic              ovf_o;

    int checks = 0;
    int errors = 0;

    exmpl_run_logger #(.CYC_W(CYC_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .A_i4        (A_i4),
        .E_i         (E_i),
        .F_i         (F_i),
        .rec_o       (rec_o),
        .rec_valid_o (rec_valid_o),
        .rec_ready_i (rec_ready_i),
        .count_o     (count_o),
        .ovf_o       (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: integer run length/E count, records kept in a queue.
    logic [REC_W-1:0] mq[$];
    bit               m_ovf = 0;
    bit               m_run = 0;
    int               m_len = 0;
    int               m_ecnt = 0;
    bit               m_pe = 0;
    bit               m_pf = 0;
    bit               m_push;
    bit               m_fr;
    logic [REC_W-1:0] m_rec;
    logic [3:0]       m_e4;
    logic [CYC_W-1:0] m_c;
    bit               live = 0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            mq.delete();
            m_ovf  = 0;
            m_run  = 0;
            m_len  = 0;
            m_ecnt = 0;
            m_pe   = 0;
            m_pf   = 0;
        end else begin
            m_push = 0;
            m_fr   = F_i && !m_pf;
            if (m_run) begin
                m_len++;
                if (E_i && !m_pe) m_ecnt++;
                if (m_fr || m_len >= MAXC) begin
                    m_e4  = (m_ecnt > 15) ? 4'hF : 4'(m_ecnt);
                    m_c   = (m_len >= MAXC) ? CYC_W'(MAXC) : CYC_W'(m_len);
                    m_rec = {~m_fr, A_i4, m_e4, m_c};
                    m_push = 1;
                    m_run  = 0;
                end
            end else if (start_i) begin
                m_run  = 1;
                m_len  = 0;
                m_ecnt = 0;
            end
            if (mq.size() != 0 && rec_ready_i) void'(mq.pop_front());
            if (m_push) begin
                if (mq.size() < DEPTH) mq.push_back(m_rec);
                else begin
`ifdef EXMPL_LOG_OVF_EN
                    m_ovf = 1;
`endif
                end
            end
            m_pe = E_i;
            m_pf = F_i;
        end
        live = 1;
    end

    always @(negedge clk_i) begin
        if (live) begin
            chk("valid", 32'(rec_valid_o), 32'(mq.size() != 0));
            chk("count", 32'(count_o), 32'(mq.size()));
            chk("ovf", 32'(ovf_o), 32'(m_ovf));
            if (mq.size() != 0) chk("rec", 32'(rec_o), 32'(mq[0]));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_i);
    endtask

    // Short run: start edge, RUN edge 1 (E optional), RUN edge 2 with F rising.
    task automatic short_run(input logic [3:0] a, input bit e1, input bit rdy_on_f);
        A_i4 = a; start_i = 1; F_i = 0; E_i = 0;
        tick();
        start_i = 0; E_i = e1;
        tick();
        E_i = 0; F_i = 1; rec_ready_i = rdy_on_f;
        tick();
        rec_ready_i = 0;
    endtask

    initial begin
        rst_i = 1; start_i = 0; A_i4 = 0; E_i = 0; F_i = 0; rec_ready_i = 0;
        tick(2);
        rst_i = 0;
        chk("reset_count", 32'(count_o), 32'd0);
        chk("reset_valid", 32'(rec_valid_o), 32'd0);
        chk("reset_ovf", 32'(ovf_o), 32'd0);

        // Reset in the middle of a run discards it.
        start_i = 1; tick();
        start_i = 0; tick(3);
        rst_i = 1; tick();
        rst_i = 0; tick();
        chk("midrst_count", 32'(count_o), 32'd0);
        chk("midrst_valid", 32'(rec_valid_o), 32'd0);

        // Basic run: E rises at RUN edges 4 and 9, F at 13.
        A_i4 = 4'b1101; start_i = 1; tick();
        start_i = 0;
        for (int n = 1; n <= 13; n++) begin
            E_i = (n == 4 || n == 5 || n == 9);
            F_i = (n == 13);
            tick();
        end
        chk("basic_valid", 32'(rec_valid_o), 32'd1);
        chk("basic_rec", 32'(rec_o), 32'(13'b0_1101_0010_1101));
        rec_ready_i = 1; tick(); rec_ready_i = 0;

        // Stale F held high: no record until F toggles; start inside RUN ignored.
        A_i4 = 4'h3; start_i = 1; tick();
        start_i = 0;
        for (int n = 1; n <= 5; n++) begin
            start_i = (n == 3);
            tick();
        end
        start_i = 0;
        chk("stale_count", 32'(count_o), 32'd0);
        F_i = 0; tick();
        F_i = 1; tick();
        chk("stale_rec", 32'(rec_o), 32'(13'b0_0011_0000_0111));
        F_i = 0; tick();
        F_i = 1; tick();
        chk("idle_frise_count", 32'(count_o), 32'd1);
        rec_ready_i = 1; tick(); rec_ready_i = 0; F_i = 0;

        // Timeout after 15 RUN edges.
        A_i4 = 4'hA; start_i = 1; tick();
        start_i = 0; tick(14);
        chk("pre_timeout_count", 32'(count_o), 32'd0);
        tick();
        chk("timeout_rec", 32'(rec_o), 32'(13'b1_1010_0000_1111));
        rec_ready_i = 1; tick(); rec_ready_i = 0;

        // Five back-to-back runs with no drain: fifth is dropped.
        for (int r = 0; r < 5; r++) short_run(4'(r + 1), bit'(r & 1), 1'b0);
        chk("full_count", 32'(count_o), 32'd4);
`ifdef EXMPL_LOG_OVF_EN
        chk("full_ovf", 32'(ovf_o), 32'd1);
`else
        chk("full_ovf", 32'(ovf_o), 32'd0);
`endif
        rec_ready_i = 1;
        for (int r = 0; r < 4; r++) begin
            chk("drain_rec", 32'(rec_o), 32'({1'b0, 4'(r + 1), 4'(r & 1), 4'd2}));
            tick();
        end
        rec_ready_i = 0;
        chk("drained_count", 32'(count_o), 32'd0);

        // Full FIFO with a pop on the push edge: push lands, no drop.
        rst_i = 1; tick(); rst_i = 0;
        for (int r = 0; r < 4; r++) short_run(4'(r + 1), bit'(r & 1), 1'b0);
        short_run(4'd5, 1'b0, 1'b1);
        chk("simul_count", 32'(count_o), 32'd4);
        chk("simul_ovf", 32'(ovf_o), 32'd0);
        chk("simul_head", 32'(rec_o), 32'(13'b0_0010_0001_0010));
        rec_ready_i = 1; tick(4); rec_ready_i = 0;
        tick(2);
        chk("final_count", 32'(count_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
